// File: rtl/nn_pkg.sv
// Shared constants and helpers for the MNIST layer datapath.
package nn_pkg;

  localparam int NN_IN_WIDTH   = 10;
  localparam int NN_DATA_WIDTH = 16;
  localparam int NN_MAX_REQ    = 16;

  // Decode a requester tag into a one-hot vector; tags at or beyond n decode to zero.
  function automatic logic [NN_MAX_REQ-1:0] onehot(input logic [3:0] tag, input int n);
    logic [NN_MAX_REQ-1:0] v;
    v = '0;
    if (int'(tag) < n) v[tag] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: grants the first active request at or after ptr.
module rr_pick #(
  parameter int N  = 4,
  parameter int TW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [TW-1:0] idx,
  output logic          any
);

  // Scan candidates ptr, ptr+1, ... wrapping at N; the first requester seen wins.
  always_comb begin
    logic [TW:0]   cand_w;
    logic [TW-1:0] cand;
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_w = '0;
    cand   = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        cand_w = {1'b0, ptr} + (TW+1)'(k);
        if (cand_w >= (TW+1)'(N)) cand_w = cand_w - (TW+1)'(N);
        cand = cand_w[TW-1:0];
        if (!any && req[cand]) begin
          any       = 1'b1;
          gnt[cand] = 1'b1;
          idx       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/sig_rom_arbiter.sv
// Shares one sigmoid ROM among NUM_REQ neuron requesters with round-robin
// arbitration, tagging each lookup so the result returns to its originator.
module sig_rom_arbiter
  import nn_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int in_width   = NN_IN_WIDTH,
  parameter int data_width = NN_DATA_WIDTH,
  parameter int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*in_width-1:0]  req_x,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [in_width-1:0]          rom_x,
  input  logic [data_width-1:0]        rom_out,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [data_width-1:0]        rsp_data,
  output logic                         busy
);

  logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  s1_valid_q;
  logic [TAG_W-1:0]      s1_tag_q;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [data_width-1:0] rsp_data_q;

  logic [NUM_REQ-1:0]    grant;
  logic [TAG_W-1:0]      grant_idx;
  logic                  grant_any;

  // Reset masks the picker so no grant (and no ROM address) leaks out during reset.
  rr_pick #(
    .N  (NUM_REQ),
    .TW (TAG_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (en && !rst),
    .gnt (grant),
    .idx (grant_idx),
    .any (grant_any)
  );

  assign req_ready = grant;

  // Steer the granted requester's x onto the ROM address; idle address is zero.
  always_comb begin
    rom_x = '0;
    if (grant_any) rom_x = req_x[int'(grant_idx)*in_width +: in_width];
  end

  // Advance the pointer past the winner, wrapping explicitly for non-power-of-two counts.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      if (int'(grant_idx) == NUM_REQ - 1) rr_ptr_d = '0;
      else                                rr_ptr_d = grant_idx + 1'b1;
    end
  end

  // Decode the tag that rides alongside the ROM latency into the response strobe.
  always_comb begin
    rsp_valid_d = '0;
    if (s1_valid_q) rsp_valid_d = NUM_REQ'(onehot(4'(s1_tag_q), NUM_REQ));
  end

  // Pointer, tag pipeline and registered response; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= grant_any;
      s1_tag_q    <= grant_idx;
      rsp_valid_q <= rsp_valid_d;
      if (s1_valid_q) rsp_data_q <= rom_out;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = s1_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// Directed self-checking bench for sig_rom_arbiter (4-requester and 3-requester instances).
module tb_sig_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  rv;
  logic [39:0] rx;
  logic [3:0]  req_ready;
  logic [9:0]  rom_x;
  logic [15:0] rom_out;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;

  logic [2:0]  rv3;
  logic [29:0] rx3;
  logic [2:0]  req_ready3;
  logic [9:0]  rom_x3;
  logic [2:0]  rsp_valid3;
  logic [15:0] rsp_data3;
  logic        busy3;

  logic [9:0]  rom_x_q;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  sig_rom_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (rv),
    .req_x     (rx),
    .req_ready (req_ready),
    .rom_x     (rom_x),
    .rom_out   (rom_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  sig_rom_arbiter #(.NUM_REQ(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (rv3),
    .req_x     (rx3),
    .req_ready (req_ready3),
    .rom_x     (rom_x3),
    .rom_out   (16'h0000),
    .rsp_valid (rsp_valid3),
    .rsp_data  (rsp_data3),
    .busy      (busy3)
  );

  // One-cycle ROM model: registered address, data = zero-extended x XOR A000.
  always_ff @(posedge clk) rom_x_q <= rom_x;
  assign rom_out = {6'b0, rom_x_q} ^ 16'hA000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setX(input int i, input logic [9:0] v);
    rx[i*10 +: 10] = v;
  endtask

  task automatic doReset;
    rst = 1'b1;
    en  = 1'b1;
    rv  = '0;
    rv3 = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b1;
    rv  = 4'b1111;
    rx  = {10'h3AA, 10'h155, 10'h2F0, 10'h0FF};
    #1;
    testsRun++;
    if (req_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
    testsRun++;
    if (rom_x !== 10'h000) begin testsFailed++; $display("[TB] FAIL reset_rom_x: got %h expected 000", rom_x); end
    tick;
    testsRun++;
    if (rsp_valid !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    testsRun++;
    if (rsp_data !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rv  = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    doReset;
    rx = '0;
    setX(2, 10'h1F3);
    rv = 4'b0100;
    #1;
    testsRun++;
    if (req_ready !== 4'b0100) begin testsFailed++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    testsRun++;
    if (rom_x !== 10'h1F3) begin testsFailed++; $display("[TB] FAIL single_rom_x: got %h expected 1f3", rom_x); end
    tick;
    rv = '0;
    testsRun++;
    if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_t1: got busy=%b rsp_valid=%b expected busy=1 rsp_valid=0000", busy, rsp_valid); end
    tick;
    testsRun++;
    if (rsp_valid !== 4'b0100) begin testsFailed++; $display("[TB] FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
    testsRun++;
    if (rsp_data !== 16'hA1F3) begin testsFailed++; $display("[TB] FAIL single_rsp_data: got %h expected a1f3", rsp_data); end
    testsRun++;
    if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_busy_t2: got %b expected 1", busy); end
    tick;
    testsRun++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_done: got rsp_valid=%b busy=%b expected 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back;
    int          g [5];
    logic [9:0]  xv [4];
    g  = '{0, 1, 2, 3, 0};
    xv = '{10'h100, 10'h111, 10'h122, 10'h133};
    doReset;
    for (int i = 0; i < 4; i++) setX(i, xv[i]);
    for (int k = 0; k < 7; k++) begin
      rv = (k < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 5) begin
        testsRun++;
        if (req_ready !== 4'(1 << g[k])) begin testsFailed++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << g[k])); end
        testsRun++;
        if (rom_x !== xv[g[k]]) begin testsFailed++; $display("[TB] FAIL b2b_rom_x[%0d]: got %h expected %h", k, rom_x, xv[g[k]]); end
      end
      if (k >= 2) begin
        testsRun++;
        if (rsp_valid !== 4'(1 << g[k-2])) begin testsFailed++; $display("[TB] FAIL b2b_rsp_valid[%0d]: got %b expected %b", k, rsp_valid, 4'(1 << g[k-2])); end
        testsRun++;
        if (rsp_data !== ({6'b0, xv[g[k-2]]} ^ 16'hA000)) begin testsFailed++; $display("[TB] FAIL b2b_rsp_data[%0d]: got %h expected %h", k, rsp_data, {6'b0, xv[g[k-2]]} ^ 16'hA000); end
      end else begin
        testsRun++;
        if (rsp_valid !== 4'b0000) begin testsFailed++; $display("[TB] FAIL b2b_rsp_idle[%0d]: got %b expected 0000", k, rsp_valid); end
      end
      tick;
    end
    testsRun++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_drain: got rsp_valid=%b busy=%b expected 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_skip_wrap;
    doReset;
    rx = '0;
    rv = 4'b0100;
    #1;
    testsRun++;
    if (req_ready !== 4'b0100) begin testsFailed++; $display("[TB] FAIL skip_first: got %b expected 0100", req_ready); end
    tick;
    rv = 4'b0101;
    #1;
    testsRun++;
    if (req_ready !== 4'b0001) begin testsFailed++; $display("[TB] FAIL skip_wrap0: got %b expected 0001", req_ready); end
    tick;
    rv = 4'b0100;
    #1;
    testsRun++;
    if (req_ready !== 4'b0100) begin testsFailed++; $display("[TB] FAIL skip_to2: got %b expected 0100", req_ready); end
    tick;
    rv = 4'b1111;
    #1;
    testsRun++;
    if (req_ready !== 4'b1000) begin testsFailed++; $display("[TB] FAIL skip_ptr3: got %b expected 1000", req_ready); end
    tick;
    rv = '0;
    tick;
    tick;
    doReset;
    rx3 = '0;
    rv3 = 3'b100;
    #1;
    testsRun++;
    if (req_ready3 !== 3'b100) begin testsFailed++; $display("[TB] FAIL n3_grant2: got %b expected 100", req_ready3); end
    tick;
    rv3 = 3'b111;
    #1;
    testsRun++;
    if (req_ready3 !== 3'b001) begin testsFailed++; $display("[TB] FAIL n3_wrap: got %b expected 001", req_ready3); end
    tick;
    testsRun++;
    if (req_ready3 !== 3'b010) begin testsFailed++; $display("[TB] FAIL n3_next: got %b expected 010", req_ready3); end
    tick;
    rv3 = '0;
    tick;
    tick;
  endtask

  task automatic test_en_gating;
    doReset;
    for (int i = 0; i < 4; i++) setX(i, 10'(10'h100 + i * 10'h011));
    rv = 4'b1111;
    #1;
    testsRun++;
    if (req_ready !== 4'b0001) begin testsFailed++; $display("[TB] FAIL en_pre_grant: got %b expected 0001", req_ready); end
    tick;
    for (int k = 0; k < 3; k++) begin
      en = 1'b0;
      #1;
      testsRun++;
      if (req_ready !== 4'b0000 || rom_x !== 10'h000) begin testsFailed++; $display("[TB] FAIL en_off[%0d]: got ready=%b rom_x=%h expected 0000/000", k, req_ready, rom_x); end
      if (k == 1) begin
        testsRun++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'hA100) begin testsFailed++; $display("[TB] FAIL en_inflight: got %b/%h expected 0001/a100", rsp_valid, rsp_data); end
      end else begin
        testsRun++;
        if (rsp_valid !== 4'b0000) begin testsFailed++; $display("[TB] FAIL en_quiet[%0d]: got %b expected 0000", k, rsp_valid); end
      end
      tick;
    end
    en = 1'b1;
    #1;
    testsRun++;
    if (req_ready !== 4'b0010) begin testsFailed++; $display("[TB] FAIL en_resume: got %b expected 0010", req_ready); end
    tick;
    rv = '0;
    tick;
    tick;
  endtask

  task automatic test_reset_midflight;
    doReset;
    rx = '0;
    setX(1, 10'h0AB);
    setX(3, 10'h05C);
    rv = 4'b0010;
    #1;
    testsRun++;
    if (req_ready !== 4'b0010) begin testsFailed++; $display("[TB] FAIL mid_accept: got %b expected 0010", req_ready); end
    tick;
    rst = 1'b1;
    rv  = 4'b1010;
    #1;
    testsRun++;
    if (req_ready !== 4'b0000 || rom_x !== 10'h000) begin testsFailed++; $display("[TB] FAIL mid_rst_comb: got ready=%b rom_x=%h expected 0000/000", req_ready, rom_x); end
    tick;
    rst = 1'b0;
    #1;
    testsRun++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_flushed: got %b/%h/%b expected 0000/0000/0", rsp_valid, rsp_data, busy); end
    testsRun++;
    if (req_ready !== 4'b0010) begin testsFailed++; $display("[TB] FAIL mid_ptr_reset: got %b expected 0010", req_ready); end
    tick;
    testsRun++;
    if (rsp_valid !== 4'b0000) begin testsFailed++; $display("[TB] FAIL mid_no_ghost: got %b expected 0000", rsp_valid); end
    rv = 4'b1000;
    tick;
    testsRun++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 16'hA0AB) begin testsFailed++; $display("[TB] FAIL mid_new_rsp: got %b/%h expected 0010/a0ab", rsp_valid, rsp_data); end
    rv = '0;
    tick;
    tick;
  endtask

  task automatic test_negative;
    doReset;
    rx = '0;
    setX(0, 10'h200);
    rv = 4'b0001;
    #1;
    testsRun++;
    if (rom_x !== 10'h200) begin testsFailed++; $display("[TB] FAIL neg_rom_x: got %h expected 200", rom_x); end
    tick;
    rv = '0;
    tick;
    testsRun++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 16'hA200) begin testsFailed++; $display("[TB] FAIL neg_rsp: got %b/%h expected 0001/a200", rsp_valid, rsp_data); end
    tick;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    rv  = '0;
    rx  = '0;
    rv3 = '0;
    rx3 = '0;
    tick;
    test_reset;
    test_single;
    test_back_to_back;
    test_skip_wrap;
    test_en_gating;
    test_reset_midflight;
    test_negative;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
